c1_bus_responder: RTL and testbench

// - Cache-side end of the CPU<->L1 C1/A1/D1 bus; the CPU acts as initiator on this bus.
// - Decodes the 2-cycle command phase, latches tag/set/offset and write data, hands one request to the cache core.
// - Drives the response phase back: C1=RESPONSE (7) plus 0, 1 or 2 D1 beats, then releases the bus.
// - Sits between the bus wires and the cache core (cache lookup and memory-side logic are out of scope).

---
 rtl/c1_bus_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_c1_bus_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1_bus_responder.sv
// c1_bus_responder: cache-side responder for the CPU<->L1 C1/A1/D1 bus.
// It accepts a two-cycle command phase from the CPU and passes one request
// to the cache core. When the core answers, it drives a RESPONSE phase on
// C1, with zero, one or two D1 beats, and then releases the bus.
// The bus is sampled on posedge and driven on negedge.
// Optional build macro: C1_RESP_STATS_EN adds saturating counters
// rd_cnt / wr_cnt / inv_cnt that count completed responses.
module c1_bus_responder #(
  parameter int TAG_W = 10,
  parameter int SET_W = 5,
  parameter int OFF_W = 4,
  parameter int A1_W  = 15,
  parameter int D1_W  = 16,
  parameter int C1_W  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [A1_W-1:0]  a1_bus,
  inout  logic [D1_W-1:0]  d1_bus,
  inout  logic [C1_W-1:0]  c1_bus,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [2:0]       req_cmd,
  output logic [TAG_W-1:0] req_tag,
  output logic [SET_W-1:0] req_set,
  output logic [OFF_W-1:0] req_off,
  output logic [31:0]      req_wdata,
  input  logic             rsp_valid,
  input  logic [31:0]      rsp_rdata,
  output logic             busy,
  output logic             proto_err
`ifdef C1_RESP_STATS_EN
  ,
  output logic [31:0]      rd_cnt,
  output logic [31:0]      wr_cnt,
  output logic [31:0]      inv_cnt
`endif
);

  // C1 command codes; WR32 and RESPONSE share the encoding 7.
  localparam logic [2:0] CMD_RD8   = 3'd1;
  localparam logic [2:0] CMD_RD16  = 3'd2;
  localparam logic [2:0] CMD_RD32  = 3'd3;
  localparam logic [2:0] CMD_INV   = 3'd4;
  localparam logic [2:0] CMD_WR32  = 3'd7;
  localparam logic [C1_W-1:0] C1_RESPONSE = C1_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD2,
    S_REQ,
    S_WAIT,
    S_RESP0,
    S_RESP1
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [2:0]        cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic [OFF_W-1:0]  off_q;
  logic [D1_W-1:0]   beat0_q;
  logic [D1_W-1:0]   beat1_q;
  logic [31:0]       rdata_q;

  logic              c1_oe;
  logic              d1_oe;
  logic [D1_W-1:0]   d1_drv;

  logic              cmd_seen;
  logic              resp_done;

  function automatic logic is_read(input logic [2:0] c);
    return (c == CMD_RD8) || (c == CMD_RD16) || (c == CMD_RD32);
  endfunction

  function automatic logic is_write(input logic [2:0] c);
    return c > CMD_INV;
  endfunction

  // The first beat carries the low half of the read data. For RD8 it is
  // zero-extended from the addressed byte.
  function automatic logic [D1_W-1:0] first_beat(input logic [2:0] c,
                                                 input logic [31:0] r);
    if (c == CMD_RD8)
      return {{(D1_W-8){1'b0}}, r[7:0]};
    return r[D1_W-1:0];
  endfunction

`ifdef C1_RESP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  // A code is a command only when it is known and nonzero. NONE, x and z
  // all fail this compare and are ignored.
  assign cmd_seen  = (c1_bus != '0);

  // The last beat is done when RESP0 finishes a single-beat response or
  // when RESP1 finishes the RD32 response.
  assign resp_done = ((state == S_RESP0) && (cmd_q != CMD_RD32)) ||
                     (state == S_RESP1);

  assign req_valid = (state == S_REQ);
  assign busy      = (state != S_IDLE);
  assign req_cmd   = cmd_q;
  assign req_tag   = tag_q;
  assign req_set   = set_q;
  assign req_off   = off_q;
  assign req_wdata = {beat1_q, beat0_q};

  assign c1_bus = c1_oe ? C1_RESPONSE : 'z;
  assign d1_bus = d1_oe ? d1_drv : 'z;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic. The FSM returns to IDLE one posedge before the
  // negedge release. The first IDLE sample therefore happens after the
  // bus has been released, so a back-to-back command is caught and the
  // responder never sees its own RESPONSE code.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_seen) state_nx = S_CMD2;
      S_CMD2:  state_nx = S_REQ;
      S_REQ:   if (req_ready) state_nx = S_WAIT;
      S_WAIT:  if (rsp_valid) state_nx = S_RESP0;
      S_RESP0: state_nx = (cmd_q == CMD_RD32) ? S_RESP1 : S_IDLE;
      S_RESP1: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Command-phase latches and read-data capture. Once REQ is reached the
  // request fields are only written in IDLE/CMD2, so they stay stable
  // while req_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q   <= '0;
      tag_q   <= '0;
      set_q   <= '0;
      off_q   <= '0;
      beat0_q <= '0;
      beat1_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_seen) begin
            cmd_q   <= c1_bus[2:0];
            tag_q   <= a1_bus[SET_W +: TAG_W];
            set_q   <= a1_bus[0 +: SET_W];
            beat0_q <= is_write(c1_bus[2:0]) ? d1_bus : '0;
          end
        end
        S_CMD2: begin
          off_q   <= a1_bus[0 +: OFF_W];
          beat1_q <= (cmd_q == CMD_WR32) ? d1_bus : '0;
        end
        S_WAIT: begin
          if (rsp_valid)
            rdata_q <= rsp_rdata;
        end
        default: ;
      endcase
    end
  end

  // Sticky protocol error. It is set when the initiator drives a code
  // while the responder owns the transaction and the bus is not in the
  // command phase or driven by the responder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      proto_err <= 1'b0;
    else if (((state == S_REQ) || (state == S_WAIT)) && cmd_seen)
      proto_err <= 1'b1;
  end

  // Bus output enables change on negedge. Reset releases both buses at
  // once, without waiting for a clock.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1_oe <= 1'b0;
      d1_oe <= 1'b0;
    end else begin
      c1_oe <= (state == S_RESP0) || (state == S_RESP1);
      d1_oe <= ((state == S_RESP0) && is_read(cmd_q)) || (state == S_RESP1);
    end
  end

  // D1 beat value. It only reaches the bus when d1_oe is set, so it needs no reset.
  always_ff @(negedge clk) begin
    d1_drv <= (state == S_RESP1) ? rdata_q[2*D1_W-1:D1_W]
                                 : first_beat(cmd_q, rdata_q);
  end

`ifdef C1_RESP_STATS_EN
  // Completed-response counters. Each bumps once, on the cycle the last
  // beat finishes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      inv_cnt <= '0;
    end else if (resp_done) begin
      if (is_read(cmd_q))
        rd_cnt <= sat_inc(rd_cnt);
      else if (is_write(cmd_q))
        wr_cnt <= sat_inc(wr_cnt);
      else if (cmd_q == CMD_INV)
        inv_cnt <= sat_inc(inv_cnt);
    end
  end
`else
  // Without the stats feature, resp_done has no consumer.
  logic unused_resp_done;
  assign unused_resp_done = resp_done;
`endif

endmodule

// File: tb/tb_c1_bus_responder.sv
// Directed testbench for c1_bus_responder.
// The bench acts as the CPU initiator and as the cache core. When the
// responder should be off the bus, the bench drives a zero background
// onto C1/D1. Any drive the responder leaves behind would corrupt that
// background value.
module tb_c1_bus_responder;

  logic        clk;
  logic        reset_n;
  logic [14:0] a1;
  logic [2:0]  c1_drv;
  logic        c1_oe;
  logic [15:0] d1_drv;
  logic        d1_oe;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  wire  [15:0] d1_bus;
  wire  [2:0]  c1_bus;
  logic        req_valid;
  logic [2:0]  req_cmd;
  logic [9:0]  req_tag;
  logic [4:0]  req_set;
  logic [3:0]  req_off;
  logic [31:0] req_wdata;
  logic        busy;
  logic        proto_err;
`ifdef C1_RESP_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] inv_cnt;
`endif

  int n_tests;
  int n_fail;

  assign c1_bus = c1_oe ? c1_drv : 'z;
  assign d1_bus = d1_oe ? d1_drv : 'z;

  c1_bus_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a1_bus    (a1),
    .d1_bus    (d1_bus),
    .c1_bus    (c1_bus),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_tag   (req_tag),
    .req_set   (req_set),
    .req_off   (req_off),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .proto_err (proto_err)
`ifdef C1_RESP_STATS_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .inv_cnt   (inv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Two-cycle command phase, then the initiator drives NONE.
  task automatic issue_cmd(input logic [2:0] cmd, input logic [9:0] tag, input logic [4:0] set,
                           input logic [3:0] off, input logic [15:0] b0, input logic [15:0] b1);
    @(negedge clk);
    c1_oe = 1'b1; c1_drv = cmd; d1_oe = 1'b1; d1_drv = b0; a1 = {tag, set};
    @(negedge clk);
    d1_drv = b1; a1 = {11'd0, off};
    @(negedge clk);
    c1_drv = 3'd0; d1_drv = 16'd0; a1 = 15'd0;
  endtask

  task automatic accept();
    @(negedge clk);
    req_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // Core answers lat cycles after WAIT entry. The bench then hands the
  // bus to the responder at the negedge where its first beat is due.
  task automatic respond(input int lat, input logic [31:0] data, input logic rel_d1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      req_ready = 1'b0;
    end
    rsp_valid = 1'b1; rsp_rdata = data;
    @(negedge clk);
    rsp_valid = 1'b0; c1_oe = 1'b0;
    if (rel_d1) d1_oe = 1'b0;
  endtask

  task automatic restore_bg();
    @(negedge clk);
    c1_oe = 1'b1; c1_drv = 3'd0; d1_oe = 1'b1; d1_drv = 16'd0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; a1 = '0; c1_oe = 1'b1; c1_drv = 3'd0; d1_oe = 1'b1; d1_drv = 16'd0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;

    // Reset state.
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_req_tag", req_tag, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_c1_released", c1_bus, 0);
    chk("rst_d1_released", d1_bus, 0);
`ifdef C1_RESP_STATS_EN
    chk("rst_rd_cnt", rd_cnt, 0);
`endif
    @(negedge clk); reset_n = 1'b1;

    // RD8 tag=0x2A set=3 off=5, core returns 0xAB after 4 cycles.
    issue_cmd(3'd1, 10'h02A, 5'd3, 4'd5, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("rd8_req_valid", req_valid, 1);
    chk("rd8_req_cmd", req_cmd, 1);
    chk("rd8_req_tag", req_tag, 32'h2A);
    chk("rd8_req_set", req_set, 3);
    chk("rd8_req_off", req_off, 5);
    chk("rd8_busy", busy, 1);
    @(posedge clk); #1;
    chk("rd8_req_hold", req_valid, 1);
    accept();
    chk("rd8_req_drop", req_valid, 0);
    chk("rd8_busy_wait", busy, 1);
    respond(4, 32'h0000_00AB, 1'b1);
    @(posedge clk); #1;
    chk("rd8_c1_resp", c1_bus, 7);
    chk("rd8_d1_beat", d1_bus, 32'h00AB);
    restore_bg();
    @(posedge clk); #1;
    chk("rd8_c1_release", c1_bus, 0);
    chk("rd8_d1_release", d1_bus, 0);
    chk("rd8_busy_end", busy, 0);

    // RD32 returning 0xDEADBEEF: two beats, low half first.
    issue_cmd(3'd3, 10'h155, 5'h1A, 4'hC, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("rd32_req_cmd", req_cmd, 3);
    chk("rd32_req_tag", req_tag, 32'h155);
    chk("rd32_req_set", req_set, 32'h1A);
    chk("rd32_req_off", req_off, 32'hC);
    accept();
    respond(2, 32'hDEAD_BEEF, 1'b1);
    @(posedge clk); #1;
    chk("rd32_c1_beat0", c1_bus, 7);
    chk("rd32_d1_beat0", d1_bus, 32'hBEEF);
    @(posedge clk); #1;
    chk("rd32_c1_beat1", c1_bus, 7);
    chk("rd32_d1_beat1", d1_bus, 32'hDEAD);
    restore_bg();
    @(posedge clk); #1;
    chk("rd32_c1_release", c1_bus, 0);
    chk("rd32_d1_release", d1_bus, 0);
    chk("rd32_busy_end", busy, 0);

    // WR32 beat0=0x5678 beat1=0x1234; the response has no D1 beat.
    issue_cmd(3'd7, 10'h3FF, 5'h1F, 4'hF, 16'h5678, 16'h1234);
    @(posedge clk); #1;
    chk("wr32_req_cmd", req_cmd, 7);
    chk("wr32_req_wdata", req_wdata, 32'h1234_5678);
    chk("wr32_req_tag", req_tag, 32'h3FF);
    accept();
    respond(1, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("wr32_c1_resp", c1_bus, 7);
    chk("wr32_d1_undriven", d1_bus, 0);
    restore_bg();
    @(posedge clk); #1;
    chk("wr32_c1_release", c1_bus, 0);
    chk("wr32_busy_end", busy, 0);

    // INV, then RD16 issued on the negedge where the bus is released.
    issue_cmd(3'd4, 10'h001, 5'h01, 4'h0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("inv_req_cmd", req_cmd, 4);
    accept();
    respond(1, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("inv_c1_resp", c1_bus, 7);
    chk("inv_d1_undriven", d1_bus, 0);
    issue_cmd(3'd2, 10'h0C3, 5'h0A, 4'h6, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("b2b_req_valid", req_valid, 1);
    chk("b2b_req_cmd", req_cmd, 2);
    chk("b2b_req_tag", req_tag, 32'h0C3);
    chk("b2b_req_off", req_off, 6);
    accept();
    respond(3, 32'hCAFE_1234, 1'b1);
    @(posedge clk); #1;
    chk("rd16_c1_resp", c1_bus, 7);
    chk("rd16_d1_beat", d1_bus, 32'h1234);
    restore_bg();
    @(posedge clk); #1;
    chk("rd16_d1_release", d1_bus, 0);
    chk("rd16_busy_end", busy, 0);
    chk("b2b_proto_err", proto_err, 0);

    // C1=1 driven during WAIT sets proto_err; the transaction still completes.
    issue_cmd(3'd1, 10'h00F, 5'd7, 4'd1, 16'h0, 16'h0);
    accept();
    @(negedge clk); req_ready = 1'b0; c1_drv = 3'd1;
    @(posedge clk); #1;
    chk("perr_set", proto_err, 1);
    chk("perr_busy", busy, 1);
    chk("perr_tag_kept", req_tag, 32'h00F);
    chk("perr_cmd_kept", req_cmd, 1);
    @(negedge clk); c1_drv = 3'd0;
    respond(1, 32'h1234_5699, 1'b1);
    @(posedge clk); #1;
    chk("perr_c1_resp", c1_bus, 7);
    chk("perr_d1_beat", d1_bus, 32'h0099);
    restore_bg();
    @(posedge clk); #1;
    chk("perr_sticky", proto_err, 1);
    chk("perr_busy_end", busy, 0);
`ifdef C1_RESP_STATS_EN
    chk("stats_rd_cnt", rd_cnt, 4);
    chk("stats_wr_cnt", wr_cnt, 1);
    chk("stats_inv_cnt", inv_cnt, 1);
`endif

    // Reset asserted while the FSM is in RESP1 of an RD32.
    issue_cmd(3'd3, 10'h111, 5'h11, 4'h2, 16'h0, 16'h0);
    accept();
    respond(1, 32'h8765_4321, 1'b1);
    @(posedge clk); #1;
    chk("rst_rd32_beat0", d1_bus, 32'h4321);
    chk("rst_rd32_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    c1_oe = 1'b1; c1_drv = 3'd0; d1_oe = 1'b1; d1_drv = 16'd0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_c1_release", c1_bus, 0);
    chk("arst_d1_release", d1_bus, 0);
    chk("arst_proto_err", proto_err, 0);
    chk("arst_req_valid", req_valid, 0);
    @(negedge clk); reset_n = 1'b1;

    // An RD8 after the reset completes normally.
    issue_cmd(3'd1, 10'h02A, 5'd3, 4'd5, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("post_req_tag", req_tag, 32'h2A);
    chk("post_req_off", req_off, 5);
    accept();
    respond(2, 32'h0000_003C, 1'b1);
    @(posedge clk); #1;
    chk("post_c1_resp", c1_bus, 7);
    chk("post_d1_beat", d1_bus, 32'h003C);
    restore_bg();
    @(posedge clk); #1;
    chk("post_c1_release", c1_bus, 0);
    chk("post_busy_end", busy, 0);
    chk("post_proto_err", proto_err, 0);
`ifdef C1_RESP_STATS_EN
    chk("post_rd_cnt", rd_cnt, 1);
    chk("post_wr_cnt", wr_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
